// File: rtl/calc_entry_fsm.sv
// Key-entry sequencer in front of the add/sub datapath: gathers A, op, B from key pulses,
// drives the adder operands, captures its result and supports chained/repeat operations.
module calc_entry_fsm #(
    parameter int WIDTH      = 6,
    parameter int DIGIT_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [4:0]       key_code,
    output logic             key_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             sub_sel,
    input  logic [WIDTH-1:0] result_in,
    output logic [WIDTH-1:0] res,
    output logic             result_valid,
    output logic [WIDTH-1:0] disp,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        EXEC    = 2'd2,
        SHOW    = 2'd3
    } state_t;

    state_t                      cur, nxt;
    logic [WIDTH-1:0]            a_nxt, b_nxt, res_nxt, disp_nxt;
    logic                        sub_nxt, rv_nxt, clear;
    logic                        accept, is_digit, is_add, is_sub, is_eq, is_clr;
    logic [WIDTH+DIGIT_BITS-1:0] a_sh, b_sh;
    logic [WIDTH-1:0]            digit;

    assign accept   = key_valid && key_ready;
    assign is_digit = (key_code <= 5'h0F);
    assign is_add   = (key_code == 5'h10);
    assign is_sub   = (key_code == 5'h11);
    assign is_eq    = (key_code == 5'h12);
    assign is_clr   = (key_code == 5'h13);
    // Shifting left drops the oldest digit bits off the top; no saturation.
    assign a_sh     = {a, key_code[DIGIT_BITS-1:0]};
    assign b_sh     = {b, key_code[DIGIT_BITS-1:0]};
    assign digit    = a_sh[WIDTH-1:0] & WIDTH'((1 << DIGIT_BITS) - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur          <= ENTER_A;
            a            <= '0;
            b            <= '0;
            sub_sel      <= 1'b0;
            res          <= '0;
            disp         <= '0;
            result_valid <= 1'b0;
        end else begin
            cur          <= nxt;
            a            <= a_nxt;
            b            <= b_nxt;
            sub_sel      <= sub_nxt;
            res          <= res_nxt;
            disp         <= disp_nxt;
            result_valid <= rv_nxt;
        end
    end

    always_comb begin
        nxt      = cur;
        a_nxt    = a;
        b_nxt    = b;
        sub_nxt  = sub_sel;
        res_nxt  = res;
        disp_nxt = disp;
        rv_nxt   = 1'b0;
        clear    = 1'b0;
        case (cur)
            ENTER_A: if (accept) begin
                if (is_digit) begin
                    a_nxt    = a_sh[WIDTH-1:0];
                    disp_nxt = a_sh[WIDTH-1:0];
                end else if (is_add || is_sub) begin
                    sub_nxt  = is_sub;
                    b_nxt    = '0;
                    disp_nxt = '0;
                    nxt      = ENTER_B;
                end else if (is_clr) begin
                    clear = 1'b1;
                end
            end
            ENTER_B: if (accept) begin
                if (is_digit) begin
                    b_nxt    = b_sh[WIDTH-1:0];
                    disp_nxt = b_sh[WIDTH-1:0];
                end else if (is_add || is_sub) begin
                    sub_nxt = is_sub;
                end else if (is_eq) begin
                    nxt = EXEC;
                end else if (is_clr) begin
                    clear = 1'b1;
                end
            end
            EXEC: begin
                res_nxt  = result_in;
                disp_nxt = result_in;
                rv_nxt   = 1'b1;
                nxt      = SHOW;
            end
            SHOW: if (accept) begin
                if (is_digit) begin
                    a_nxt    = digit;
                    b_nxt    = '0;
                    sub_nxt  = 1'b0;
                    disp_nxt = digit;
                    nxt      = ENTER_A;
                end else if (is_add || is_sub) begin
                    a_nxt    = res;
                    b_nxt    = '0;
                    sub_nxt  = is_sub;
                    disp_nxt = '0;
                    nxt      = ENTER_B;
                end else if (is_eq) begin
                    a_nxt = res;
                    nxt   = EXEC;
                end else if (is_clr) begin
                    clear = 1'b1;
                end
            end
            default: clear = 1'b1;
        endcase
        // 'C' and corrupted state both land on the reset image.
        if (clear) begin
            nxt      = ENTER_A;
            a_nxt    = '0;
            b_nxt    = '0;
            sub_nxt  = 1'b0;
            res_nxt  = '0;
            disp_nxt = '0;
            rv_nxt   = 1'b0;
        end
    end

    always_comb begin
        key_ready = (cur != EXEC);
        state     = cur;
    end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed bench for calc_entry_fsm: an arithmetic key-entry model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_calc_entry_fsm;
    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_ready, sub_sel, result_valid;
    logic [5:0] a, b, result_in, res, disp;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    calc_entry_fsm #(.WIDTH(6), .DIGIT_BITS(4)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .a(a), .b(b), .sub_sel(sub_sel),
        .result_in(result_in), .res(res), .result_valid(result_valid),
        .disp(disp), .state(state)
    );

    // Stand-in for the external adder.
    assign result_in = sub_sel ? (a - b) : (a + b);

    always #5 clk = ~clk;

    // Model: mode 0=entering A, 1=entering B, 2=computing, 3=showing.
    int m_mode, m_a, m_b, m_sub, m_res, m_disp, m_rv;
    bit m_init = 1'b0;

    task automatic m_clear();
        m_mode = 0; m_a = 0; m_b = 0; m_sub = 0; m_res = 0; m_disp = 0; m_rv = 0;
    endtask

    always @(posedge clk) begin
        int c;
        if (rst) begin
            m_clear();
            m_init = 1'b1;
        end else if (m_init) begin
            m_rv = 0;
            c = key_code;
            if (m_mode == 2) begin
                m_res  = m_sub ? (m_a - m_b + 64) % 64 : (m_a + m_b) % 64;
                m_disp = m_res;
                m_rv   = 1;
                m_mode = 3;
            end else if (key_valid) begin
                if (c == 8'h13) m_clear();
                else if (c < 16) begin
                    if (m_mode == 0)      begin m_a = (m_a * 16 + c) % 64; m_disp = m_a; end
                    else if (m_mode == 1) begin m_b = (m_b * 16 + c) % 64; m_disp = m_b; end
                    else begin m_a = c; m_b = 0; m_sub = 0; m_disp = c; m_mode = 0; end
                end else if (c == 8'h10 || c == 8'h11) begin
                    if (m_mode == 1) m_sub = c - 16;
                    else begin
                        if (m_mode == 3) m_a = m_res;
                        m_sub = c - 16; m_b = 0; m_disp = 0; m_mode = 1;
                    end
                end else if (c == 8'h12) begin
                    if (m_mode == 1) m_mode = 2;
                    else if (m_mode == 3) begin m_a = m_res; m_mode = 2; end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("state", state, m_mode);
            chk("a", a, m_a);
            chk("b", b, m_b);
            chk("sub_sel", sub_sel, m_sub);
            chk("res", res, m_res);
            chk("disp", disp, m_disp);
            chk("result_valid", result_valid, m_rv);
            chk("key_ready", key_ready, (m_mode != 2) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic key(input int c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 5'(c);
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = '0;
        tick(); tick();
        rst = 1'b0;
        chk("lit_reset_state", state, 0);
        chk("lit_reset_ready", key_ready, 1);

        // 2 + 3 =
        key(2); key(8'h10); key(3); key(8'h12);
        chk("lit_exec_state", state, 2);
        chk("lit_exec_ready", key_ready, 0);
        tick();
        chk("lit_t1_a", a, 2); chk("lit_t1_b", b, 3); chk("lit_t1_res", res, 5);
        chk("lit_t1_rv", result_valid, 1);
        tick();
        chk("lit_t1_rv_drop", result_valid, 0);

        // chain and repeat
        key(8'h10); key(1); key(8'h12); tick();
        chk("lit_t3_a", a, 5); chk("lit_t3_b", b, 1); chk("lit_t3_res", res, 6);
        key(8'h12); tick();
        chk("lit_t3_a2", a, 6); chk("lit_t3_res2", res, 7);
        key(8'h12); tick();
        chk("lit_t3_res3", res, 8);
        key(9);
        chk("lit_show_digit_a", a, 9); chk("lit_show_digit_state", state, 0);

        // subtract and wrap
        key(8'h13); key(6); key(8'h11); key(3); key(8'h12); tick();
        chk("lit_t2_res", res, 3);
        key(8'h13); key(0); key(8'h11); key(8'hE); key(8'h12); tick();
        chk("lit_t2_wrap", res, 8'h32);

        // truncation, ignored codes, operator replace
        key(8'h13); key(1);
        chk("lit_t4_a1", a, 1);
        key(2);
        chk("lit_t4_a2", a, 8'h12);
        key(3); key(8'h15); key(8'h12);
        chk("lit_t4_a3", a, 8'h23); chk("lit_t4_stay", state, 0);
        key(8'h10); key(5); key(8'h10); key(8'h11);
        chk("lit_t4_sub", sub_sel, 1); chk("lit_t4_b", b, 5);

        // key held through EXEC is dropped
        @(negedge clk); key_valid = 1'b1; key_code = 5'h12;
        tick();
        key_code = 5'h13;
        chk("lit_t5_ready", key_ready, 0);
        tick();
        key_valid = 1'b0;
        chk("lit_t5_state", state, 3); chk("lit_t5_res", res, 8'h1E);
        chk("lit_t5_a", a, 8'h23);
        key(8'h10); key(7); key(8'h13);
        chk("lit_t5_clr_state", state, 0); chk("lit_t5_clr_a", a, 0); chk("lit_t5_clr_res", res, 0);

        // reset during EXEC
        key(4); key(8'h10); key(1); key(8'h12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lit_t6_res", res, 0); chk("lit_t6_rv", result_valid, 0); chk("lit_t6_state", state, 0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
